// File: rtl/tc_bit_arb_pkg.sv
// rtl/tc_bit_arb_pkg.sv - shared types and round-robin pick for the bit-memory arbiter
package tc_bit_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        CLEAR  = 2'd2
    } arb_state_e;

    // First set request at or after ptr, wrapping at n-1 -> 0; one-hot result.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req_vec,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] pick;
        logic [2:0]         idx;
        logic               found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = 3'((int'(ptr) + k) % n);
            if (k < n && !found && req_vec[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tc_bit_bank.sv
// rtl/tc_bit_bank.sv - single-bit cell bank, one write port, one combinational read port
module tc_bit_bank #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic [AW-1:0] raddr,
    output logic          rdata
);

    logic [DEPTH-1:0] cells_q;
    logic [DEPTH-1:0] cells_d;

    always_comb begin
        cells_d = cells_q;
        if (we && (int'(waddr) < DEPTH)) begin
            cells_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cells_q <= '0;
        end else begin
            cells_q <= cells_d;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? cells_q[raddr] : 1'b0;

endmodule

// File: rtl/tc_bit_memory_arbiter.sv
// rtl/tc_bit_memory_arbiter.sv - round-robin arbiter owning all accesses to a shared bit bank
module tc_bit_memory_arbiter
    import tc_bit_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0]               we,
    input  logic [NREQ*$clog2(DEPTH)-1:0] addr,
    input  logic [NREQ-1:0]               wdata,
    input  logic                          clear,
    output logic [NREQ-1:0]               gnt,
    output logic [NREQ-1:0]               ack,
    output logic                          rdata,
    output logic                          busy,
    output logic                          clear_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NREQ);

    arb_state_e       state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             clear_pend_q, clear_pend_d;
    logic             lat_we_q, lat_we_d;
    logic [AW-1:0]    lat_addr_q, lat_addr_d;
    logic             lat_wdata_q, lat_wdata_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             clear_done_q, clear_done_d;

    logic             bank_we;
    logic [AW-1:0]    bank_waddr;
    logic             bank_wdata;
    logic             bank_rdata;
    logic [MAX_REQ-1:0] pick;
    logic             unused_pick;

    assign pick        = rr_pick(MAX_REQ'(req), 3'(rr_ptr_q), NREQ);
    assign unused_pick = ^pick;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        clear_pend_d = clear_pend_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        ack_d        = '0;
        rdata_d      = 1'b0;
        clear_done_d = 1'b0;
        bank_we      = 1'b0;
        bank_waddr   = lat_addr_q;
        bank_wdata   = lat_wdata_q;

        case (state_q)
            IDLE: begin
                // Clear has priority over requests; the pointer is left untouched.
                if (clear || clear_pend_q) begin
                    state_d      = CLEAR;
                    cnt_d        = '0;
                    clear_pend_d = 1'b0;
                end else if (|req) begin
                    state_d = ACCESS;
                    gnt_d   = pick[NREQ-1:0];
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick[i]) begin
                            lat_we_d    = we[i];
                            lat_addr_d  = addr[i*AW +: AW];
                            lat_wdata_d = wdata[i];
                            rr_ptr_d    = PW'((i + 1) % NREQ);
                        end
                    end
                end
            end
            ACCESS: begin
                bank_we = lat_we_q;
                rdata_d = bank_rdata;
                ack_d   = gnt_q;
                gnt_d   = '0;
                state_d = IDLE;
                if (clear) begin
                    clear_pend_d = 1'b1;
                end
            end
            CLEAR: begin
                // A clear seen here is absorbed into the pass already running.
                bank_we    = 1'b1;
                bank_waddr = cnt_q;
                bank_wdata = 1'b0;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d      = IDLE;
                    clear_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            clear_pend_q <= 1'b0;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= 1'b0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            ack_q        <= '0;
            rdata_q      <= 1'b0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            clear_pend_q <= clear_pend_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    tc_bit_bank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .raddr (lat_addr_q),
        .rdata (bank_rdata)
    );

    assign gnt        = gnt_q;
    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign busy       = busy_q;
    assign clear_done = clear_done_q;

endmodule

// File: doc/tc_bit_memory_arbiter.md
# tc_bit_memory_arbiter

Shares one bank of single-bit storage cells between `NREQ` requesters. Each requester issues an addressed read or swap-write; a round-robin arbiter grants one access at a time and returns the prior bit value with a one-cycle acknowledge. A sequenced bulk-clear zeroes the bank one cell per cycle. The block sits between component-level bit consumers and the storage, as the single owner of every save/in strobe into the bank.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `DEPTH`, 8: number of bit cells, 2..64
- `AW`, `$clog2(DEPTH)`: address width, derived, not overridden
- `clk`  input  1  clock; all state on rising edge
- `rst`  input  1  reset, asynchronous, active-low
- `req`  input  NREQ  per-requester request level
- `we`  input  NREQ  per-requester write flag; 1 = swap-write, 0 = read
- `addr`  input  NREQ*AW  per-requester cell address, requester i at bits [i*AW +: AW]
- `wdata`  input  NREQ  per-requester write bit
- `clear`  input  1  bulk-clear request, sampled level
- `gnt`  output  NREQ  one-hot grant, registered
- `ack`  output  NREQ  one-hot one-cycle completion pulse, registered
- `rdata`  output  1  cell value before the access, valid while any `ack` is high
- `busy`  output  1  high in ACCESS and CLEAR
- `clear_done`  output  1  one-cycle pulse after the last cell is cleared

## Operation
- FSM states: IDLE, ACCESS, CLEAR.
- IDLE: `clear` or `clear_pend` set → CLEAR, counter=0. Else any `req` set → winner chosen, `gnt` set, winner's `we`/`addr`/`wdata` latched → ACCESS. Else stay.
- Arbitration: round-robin. Search starts at `rr_ptr`, wraps at NREQ-1→0. After a grant to i, `rr_ptr` = (i+1) mod NREQ.
- ACCESS lasts one cycle. `rdata` takes the old cell value. If `we`, the cell takes the latched `wdata`. `ack[i]` pulses, `gnt` clears, next state IDLE.
- Address ≥ DEPTH: no write, `rdata`=0, `ack` is still issued.
- `clear` seen in ACCESS sets `clear_pend`. The in-flight access completes first. `clear_pend` is cleared on entry to CLEAR.
- CLEAR: zeroes the cell at `counter` each cycle, counter +1. After DEPTH cycles, `clear_done` pulses with the return to IDLE. `clear` asserted during CLEAR is absorbed; no second pass runs. `req` is held off.
- Requesters hold `req`/`we`/`addr`/`wdata` stable until they see `ack`. A `req` still high on the edge after `ack` counts as a new request.

## Timing
- Reset (`rst`=0, async): `gnt`=0, `ack`=0, `rdata`=0, `busy`=0, `clear_done`=0, all cells 0, `rr_ptr`=0, `clear_pend`=0, state IDLE.
- Reset released mid-ACCESS or mid-CLEAR: the operation is abandoned with no `ack`/`clear_done`. The bank is already zero.
- Edge k: IDLE samples `req` → `gnt` high during cycle k.
- Edge k+1: write commits, `ack`+`rdata` valid during cycle k+1.
- Access latency is 2 edges from the sampled request to `ack`. Peak throughput is 1 access per 2 cycles.
- A write is visible to any access granted at edge k+2 or later.
- Clear: DEPTH cycles in CLEAR plus 1 IDLE edge to enter. `clear_done` is high in the cycle after the last cell is zeroed.
- Clear versus request at the same IDLE edge: clear wins. `rr_ptr` is unchanged.

## Structure
- Package `tc_bit_arb_pkg`: state enum (IDLE, ACCESS, CLEAR), the round-robin pick function (request vector, pointer → one-hot).
- Sub-module `tc_bit_bank`:
  - DEPTH cells, async active-low clear.
  - One write port (we, waddr, wdata).
  - One combinational read port.
  - Writes to out-of-range addresses are ignored.
- The top level holds the FSM, `rr_ptr`, the latched request fields, the clear counter and the output registers.

## Test plan
- Single read after reset: NREQ=4, req[2]=1, we=0, addr=5 → `gnt`=4'b0100 next cycle, then `ack`=4'b0100 with `rdata`=0.
- Swap-write then read: req0 write addr=3 data=1, then read addr=3 → first `rdata`=0, second `rdata`=1.
- Fairness: all four `req` held continuously, each requester re-requests right after its ack → grant order 0,1,2,3,0,…, 2 cycles per ack, no requester starved.
- Clear collision: `clear` asserted in the ACCESS cycle of a req1 write to addr=7 → ack1 issued, then CLEAR for 8 cycles, then `clear_done`, then read addr=7 returns 0.
- Async reset mid-CLEAR: cells preloaded with 1, `rst`=0 at counter=3 → all outputs 0 immediately, no `clear_done`, reads of all addresses return 0.
- Out-of-range: DEPTH=6, write addr=7 data=1 → ack issued, `rdata`=0, cells 0..5 unchanged.
